// File: rtl/nfc_ram_arb_pkg.sv
// Shared encodings for the NFC buffer RAM arbiter: FSM states, RAM write-enable codes
// and the read-return requester tag.
package nfc_ram_arb_pkg;

    localparam logic [1:0] ARB_ST_ARB      = 2'b00;
    localparam logic [1:0] ARB_ST_RMW_RD   = 2'b01;
    localparam logic [1:0] ARB_ST_RMW_WAIT = 2'b10;
    localparam logic [1:0] ARB_ST_RMW_WR   = 2'b11;

    localparam logic [1:0] RAM_WEN_RD = 2'b11;
    localparam logic [1:0] RAM_WEN_WR = 2'b00;

    typedef enum logic [1:0] {
        RdIdNone = 2'b00,
        RdIdMif  = 2'b01,
        RdIdHst  = 2'b10
    } rd_id_e;

endpackage

// File: rtl/nfc_ram_rdpipe.sv
// Two-stage requester-ID pipeline aligning read-valid strobes with RAM output data.
module nfc_ram_rdpipe
    import nfc_ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mif_rd_i,
    input  logic hst_rd_i,
    input  logic rmw_rd_i,
    output logic mif_rvld_o,
    output logic hst_rvld_o
);

    rd_id_e s1_d, s1_q, s2_q;

    // RMW reads are consumed internally and never surface as a requester strobe.
    always_comb begin
        s1_d = RdIdNone;
        if (!rmw_rd_i) begin
            if (mif_rd_i) begin
                s1_d = RdIdMif;
            end else if (hst_rd_i) begin
                s1_d = RdIdHst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RdIdNone;
            s2_q <= RdIdNone;
        end else begin
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    assign mif_rvld_o = (s2_q == RdIdMif);
    assign hst_rvld_o = (s2_q == RdIdHst);

endmodule

// File: rtl/nfc_ram_arb.sv
// Single-port NFC buffer RAM arbiter: MIF > ECC read-modify-write > host, with a host
// starvation guard. RAM command outputs are registered one cycle after the grant.
module nfc_ram_arb
    import nfc_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WID     = 13,
    parameter int unsigned HST_MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mif_req,
    input  logic                mif_wr,
    input  logic [ADDR_WID-1:0] mif_addr,
    input  logic [15:0]         mif_wdat,
    output logic                mif_gnt,
    output logic                mif_rvld,
    input  logic                ecc_cor_req,
    input  logic [ADDR_WID-1:0] ecc_cor_addr,
    input  logic [15:0]         ecc_cor_mask,
    output logic                ecc_cor_gnt,
    output logic                ecc_cor_done,
    input  logic                hst_req,
    input  logic                hst_wr,
    input  logic [1:0]          hst_be,
    input  logic [ADDR_WID-1:0] hst_addr,
    input  logic [15:0]         hst_wdat,
    output logic                hst_gnt,
    output logic                hst_rvld,
    output logic [15:0]         rdat,
    output logic [ADDR_WID-1:0] nfc_ram_addr,
    output logic                nfc_ram_cen,
    output logic [1:0]          nfc_ram_wen,
    output logic [15:0]         nfc_ram_din,
    input  logic [15:0]         ram_nfc_dout
);

    localparam int unsigned      WaitW   = (HST_MAX_WAIT > 0) ? $clog2(HST_MAX_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(HST_MAX_WAIT);

    logic [1:0]          state_d, state_q;
    logic [WaitW-1:0]    wait_d, wait_q;
    logic [ADDR_WID-1:0] ecc_addr_d, ecc_addr_q;
    logic [15:0]         ecc_mask_d, ecc_mask_q;
    logic [ADDR_WID-1:0] addr_d, addr_q;
    logic                cen_d, cen_q;
    logic [1:0]          wen_d, wen_q;
    logic [15:0]         din_d, din_q;
    logic                hst_force;

    assign hst_force = hst_req && (wait_q == WaitMax);

    always_comb begin
        mif_gnt     = 1'b0;
        ecc_cor_gnt = 1'b0;
        hst_gnt     = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        ecc_addr_d  = ecc_addr_q;
        ecc_mask_d  = ecc_mask_q;
        cen_d       = 1'b1;
        wen_d       = RAM_WEN_RD;
        addr_d      = addr_q;
        din_d       = din_q;

        unique case (state_q)
            ARB_ST_ARB: begin
                if (hst_force) begin
                    hst_gnt = 1'b1;
                end else if (mif_req) begin
                    mif_gnt = 1'b1;
                end else if (ecc_cor_req) begin
                    ecc_cor_gnt = 1'b1;
                end else if (hst_req) begin
                    hst_gnt = 1'b1;
                end

                if (mif_gnt) begin
                    cen_d  = 1'b0;
                    addr_d = mif_addr;
                    if (mif_wr) begin
                        wen_d = RAM_WEN_WR;
                        din_d = mif_wdat;
                    end
                end

                // A host write with no byte enables is accepted but never reaches the RAM.
                if (hst_gnt && (!hst_wr || (hst_be != 2'b00))) begin
                    cen_d  = 1'b0;
                    addr_d = hst_addr;
                    if (hst_wr) begin
                        wen_d = ~hst_be;
                        din_d = hst_wdat;
                    end
                end

                if (ecc_cor_gnt) begin
                    cen_d      = 1'b0;
                    addr_d     = ecc_cor_addr;
                    ecc_addr_d = ecc_cor_addr;
                    ecc_mask_d = ecc_cor_mask;
                    state_d    = ARB_ST_RMW_RD;
                end
            end
            ARB_ST_RMW_RD: begin
                state_d = ARB_ST_RMW_WAIT;
            end
            ARB_ST_RMW_WAIT: begin
                // RAM read data is valid now; register the corrected write-back.
                cen_d   = 1'b0;
                wen_d   = RAM_WEN_WR;
                addr_d  = ecc_addr_q;
                din_d   = ram_nfc_dout ^ ecc_mask_q;
                state_d = ARB_ST_RMW_WR;
            end
            ARB_ST_RMW_WR: begin
                state_d = ARB_ST_ARB;
            end
            default: begin
                state_d = ARB_ST_ARB;
            end
        endcase

        if (hst_gnt) begin
            wait_d = '0;
        end else if (hst_req && (wait_q != WaitMax)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_ST_ARB;
            wait_q     <= '0;
            ecc_addr_q <= '0;
            ecc_mask_q <= '0;
            addr_q     <= '0;
            cen_q      <= 1'b1;
            wen_q      <= RAM_WEN_RD;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ecc_addr_q <= ecc_addr_d;
            ecc_mask_q <= ecc_mask_d;
            addr_q     <= addr_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            din_q      <= din_d;
        end
    end

    assign nfc_ram_addr = addr_q;
    assign nfc_ram_cen  = cen_q;
    assign nfc_ram_wen  = wen_q;
    assign nfc_ram_din  = din_q;
    assign ecc_cor_done = (state_q == ARB_ST_RMW_WR);

    nfc_ram_rdpipe u_rdpipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif_rd_i   (mif_gnt & ~mif_wr),
        .hst_rd_i   (hst_gnt & ~hst_wr),
        .rmw_rd_i   (ecc_cor_gnt),
        .mif_rvld_o (mif_rvld),
        .hst_rvld_o (hst_rvld)
    );

    // The RAM macro output is already registered; only qualify it.
    assign rdat = (mif_rvld | hst_rvld) ? ram_nfc_dout : 16'h0000;

endmodule

// File: tb/tb_nfc_ram_arb.sv
// Self-checking bench for nfc_ram_arb: directed scenarios plus randomized traffic against
// a transaction-level memory and grant model, with a behavioural RAM macro.
module tb_nfc_ram_arb;

    localparam int AW   = 13;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          mif_req, mif_wr, mif_gnt, mif_rvld;
    logic [AW-1:0] mif_addr;
    logic [15:0]   mif_wdat;
    logic          ecc_cor_req, ecc_cor_gnt, ecc_cor_done;
    logic [AW-1:0] ecc_cor_addr;
    logic [15:0]   ecc_cor_mask;
    logic          hst_req, hst_wr, hst_gnt, hst_rvld;
    logic [1:0]    hst_be;
    logic [AW-1:0] hst_addr;
    logic [15:0]   hst_wdat;
    logic [15:0]   rdat;
    logic [AW-1:0] nfc_ram_addr;
    logic          nfc_ram_cen;
    logic [1:0]    nfc_ram_wen;
    logic [15:0]   nfc_ram_din;
    logic [15:0]   ram_dout = 16'h0000;

    logic [15:0]   mem [0:8191];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [15:0]   bd_dat;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        bit          hst;
        logic [15:0] data;
    } rsp_t;

    always #5 clk = ~clk;

    nfc_ram_arb #(
        .ADDR_WID     (AW),
        .HST_MAX_WAIT (MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mif_req      (mif_req),
        .mif_wr       (mif_wr),
        .mif_addr     (mif_addr),
        .mif_wdat     (mif_wdat),
        .mif_gnt      (mif_gnt),
        .mif_rvld     (mif_rvld),
        .ecc_cor_req  (ecc_cor_req),
        .ecc_cor_addr (ecc_cor_addr),
        .ecc_cor_mask (ecc_cor_mask),
        .ecc_cor_gnt  (ecc_cor_gnt),
        .ecc_cor_done (ecc_cor_done),
        .hst_req      (hst_req),
        .hst_wr       (hst_wr),
        .hst_be       (hst_be),
        .hst_addr     (hst_addr),
        .hst_wdat     (hst_wdat),
        .hst_gnt      (hst_gnt),
        .hst_rvld     (hst_rvld),
        .rdat         (rdat),
        .nfc_ram_addr (nfc_ram_addr),
        .nfc_ram_cen  (nfc_ram_cen),
        .nfc_ram_wen  (nfc_ram_wen),
        .nfc_ram_din  (nfc_ram_din),
        .ram_nfc_dout (ram_dout)
    );

    // Behavioural single-port RAM macro with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_dat;
        end else if (!nfc_ram_cen) begin
            if (nfc_ram_wen == 2'b11) begin
                ram_dout <= mem[nfc_ram_addr];
            end else begin
                if (!nfc_ram_wen[1]) mem[nfc_ram_addr][15:8] <= nfc_ram_din[15:8];
                if (!nfc_ram_wen[0]) mem[nfc_ram_addr][7:0]  <= nfc_ram_din[7:0];
            end
        end
    end

    task automatic idle_inputs();
        mif_req = 1'b0; mif_wr = 1'b0; mif_addr = '0; mif_wdat = '0;
        ecc_cor_req = 1'b0; ecc_cor_addr = '0; ecc_cor_mask = '0;
        hst_req = 1'b0; hst_wr = 1'b0; hst_be = 2'b00; hst_addr = '0; hst_wdat = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_dat  = d;
        bd_we   = 1'b1;
        next_cycle();
        bd_we   = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (nfc_ram_cen !== 1'b1) begin bad++;
            $display("FAIL reset_cen got=%b want=1", nfc_ram_cen); end
        total++; if (nfc_ram_wen !== 2'b11) begin bad++;
            $display("FAIL reset_wen got=%b want=11", nfc_ram_wen); end
        total++; if (nfc_ram_addr !== '0) begin bad++;
            $display("FAIL reset_addr got=%h want=0", nfc_ram_addr); end
        total++; if (nfc_ram_din !== 16'h0) begin bad++;
            $display("FAIL reset_din got=%h want=0", nfc_ram_din); end
        total++; if ({mif_gnt, ecc_cor_gnt, hst_gnt} !== 3'b000) begin bad++;
            $display("FAIL reset_gnt got=%b want=000", {mif_gnt, ecc_cor_gnt, hst_gnt}); end
        total++; if ({mif_rvld, hst_rvld, ecc_cor_done} !== 3'b000) begin bad++;
            $display("FAIL reset_rvld got=%b want=000", {mif_rvld, hst_rvld, ecc_cor_done}); end
        total++; if (rdat !== 16'h0) begin bad++;
            $display("FAIL reset_rdat got=%h want=0", rdat); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_mif_read();
        bd_write(13'h010, 16'h5A5A);
        mif_req = 1'b1; mif_wr = 1'b0; mif_addr = 13'h010;
        @(negedge clk);
        total++; if (mif_gnt !== 1'b1) begin bad++;
            $display("FAIL mif_rd_gnt got=%b want=1", mif_gnt); end
        next_cycle();
        mif_req = 1'b0;
        @(negedge clk);
        total++; if ({nfc_ram_cen, nfc_ram_wen, nfc_ram_addr} !== {1'b0, 2'b11, 13'h010}) begin
            bad++; $display("FAIL mif_rd_cmd got cen=%b wen=%b addr=%h want cen=0 wen=11 addr=010",
                            nfc_ram_cen, nfc_ram_wen, nfc_ram_addr); end
        next_cycle();
        @(negedge clk);
        total++; if ({mif_rvld, hst_rvld} !== 2'b10 || rdat !== 16'h5A5A) begin bad++;
            $display("FAIL mif_rd_data got rvld=%b%b rdat=%h want rvld=10 rdat=5a5a",
                     mif_rvld, hst_rvld, rdat); end
        next_cycle();
    endtask

    task automatic test_starvation();
        mif_req = 1'b1; mif_wr = 1'b0; mif_addr = 13'h020;
        hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 13'h021;
        for (int k = 1; k <= MAXW; k++) begin
            @(negedge clk);
            total++; if ({mif_gnt, hst_gnt} !== 2'b10) begin bad++;
                $display("FAIL starve_mif_%0d got=%b want=10", k, {mif_gnt, hst_gnt}); end
            next_cycle();
        end
        @(negedge clk);
        total++; if ({mif_gnt, hst_gnt} !== 2'b01) begin bad++;
            $display("FAIL starve_hst_win got=%b want=01", {mif_gnt, hst_gnt}); end
        next_cycle();
        hst_req = 1'b0;
        @(negedge clk);
        total++; if ({mif_gnt, hst_gnt} !== 2'b10) begin bad++;
            $display("FAIL starve_mif_resume got=%b want=10", {mif_gnt, hst_gnt}); end
        next_cycle();
        mif_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_ecc_rmw();
        bd_write(13'h1F0, 16'h1234);
        ecc_cor_req = 1'b1; ecc_cor_addr = 13'h1F0; ecc_cor_mask = 16'h0010;
        @(negedge clk);
        total++; if ({ecc_cor_gnt, mif_gnt} !== 2'b10) begin bad++;
            $display("FAIL ecc_gnt got=%b want=10", {ecc_cor_gnt, mif_gnt}); end
        next_cycle();
        ecc_cor_req = 1'b0;
        mif_req = 1'b1; mif_wr = 1'b0; mif_addr = 13'h031;
        @(negedge clk);
        total++; if ({mif_gnt, nfc_ram_cen, nfc_ram_wen, nfc_ram_addr} !==
                     {1'b0, 1'b0, 2'b11, 13'h1F0}) begin bad++;
            $display("FAIL ecc_rd got gnt=%b cen=%b wen=%b addr=%h want gnt=0 cen=0 wen=11 addr=1f0",
                     mif_gnt, nfc_ram_cen, nfc_ram_wen, nfc_ram_addr); end
        next_cycle();
        @(negedge clk);
        total++; if ({mif_gnt, nfc_ram_cen} !== 2'b01) begin bad++;
            $display("FAIL ecc_wait got gnt=%b cen=%b want gnt=0 cen=1", mif_gnt, nfc_ram_cen); end
        next_cycle();
        @(negedge clk);
        total++; if ({mif_gnt, nfc_ram_cen, nfc_ram_wen, nfc_ram_addr, nfc_ram_din, ecc_cor_done} !==
                     {1'b0, 1'b0, 2'b00, 13'h1F0, 16'h1224, 1'b1}) begin bad++;
            $display("FAIL ecc_wr got gnt=%b cen=%b wen=%b addr=%h din=%h done=%b want 0 0 00 1f0 1224 1",
                     mif_gnt, nfc_ram_cen, nfc_ram_wen, nfc_ram_addr, nfc_ram_din, ecc_cor_done); end
        next_cycle();
        @(negedge clk);
        total++; if ({mif_gnt, ecc_cor_done} !== 2'b10) begin bad++;
            $display("FAIL ecc_after got gnt=%b done=%b want gnt=1 done=0", mif_gnt, ecc_cor_done); end
        next_cycle();
        mif_req = 1'b0;
        repeat (3) next_cycle();
        total++; if (mem[13'h1F0] !== 16'h1224) begin bad++;
            $display("FAIL ecc_mem got=%h want=1224", mem[13'h1F0]); end
    endtask

    task automatic test_host_be();
        bd_write(13'h040, 16'h1111);
        hst_req = 1'b1; hst_wr = 1'b1; hst_be = 2'b10; hst_addr = 13'h040; hst_wdat = 16'hABCD;
        @(negedge clk);
        total++; if (hst_gnt !== 1'b1) begin bad++;
            $display("FAIL hst_wr_gnt got=%b want=1", hst_gnt); end
        next_cycle();
        hst_req = 1'b0;
        @(negedge clk);
        total++; if ({nfc_ram_cen, nfc_ram_wen, nfc_ram_din} !== {1'b0, 2'b01, 16'hABCD}) begin bad++;
            $display("FAIL hst_wr_cmd got cen=%b wen=%b din=%h want cen=0 wen=01 din=abcd",
                     nfc_ram_cen, nfc_ram_wen, nfc_ram_din); end
        next_cycle();
        hst_req = 1'b1; hst_wr = 1'b0;
        @(negedge clk);
        next_cycle();
        hst_req = 1'b0;
        next_cycle();
        @(negedge clk);
        total++; if (hst_rvld !== 1'b1 || rdat !== 16'hAB11) begin bad++;
            $display("FAIL hst_rd_back got rvld=%b rdat=%h want rvld=1 rdat=ab11", hst_rvld, rdat); end
        next_cycle();
        hst_req = 1'b1; hst_wr = 1'b1; hst_be = 2'b00; hst_wdat = 16'hFFFF;
        @(negedge clk);
        total++; if (hst_gnt !== 1'b1) begin bad++;
            $display("FAIL hst_be0_gnt got=%b want=1", hst_gnt); end
        next_cycle();
        hst_req = 1'b0;
        @(negedge clk);
        total++; if ({nfc_ram_cen, nfc_ram_wen} !== 3'b111) begin bad++;
            $display("FAIL hst_be0_cmd got cen=%b wen=%b want cen=1 wen=11", nfc_ram_cen, nfc_ram_wen); end
        repeat (2) next_cycle();
        total++; if (mem[13'h040] !== 16'hAB11) begin bad++;
            $display("FAIL hst_be0_mem got=%h want=ab11", mem[13'h040]); end
    endtask

    task automatic test_back_to_back();
        bd_write(13'h001, 16'h0A01);
        bd_write(13'h002, 16'h0B02);
        bd_write(13'h003, 16'h0C03);
        mif_req = 1'b1; mif_wr = 1'b0; mif_addr = 13'h001;
        @(negedge clk);
        total++; if ({mif_gnt, hst_gnt} !== 2'b10) begin bad++;
            $display("FAIL b2b_gnt0 got=%b want=10", {mif_gnt, hst_gnt}); end
        next_cycle();
        mif_req = 1'b0; hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 13'h002;
        @(negedge clk);
        total++; if ({mif_gnt, hst_gnt} !== 2'b01) begin bad++;
            $display("FAIL b2b_gnt1 got=%b want=01", {mif_gnt, hst_gnt}); end
        next_cycle();
        hst_req = 1'b0; mif_req = 1'b1; mif_addr = 13'h003;
        @(negedge clk);
        total++; if ({mif_gnt, mif_rvld, hst_rvld} !== 3'b110 || rdat !== 16'h0A01) begin bad++;
            $display("FAIL b2b_rv0 got gnt=%b rvld=%b%b rdat=%h want gnt=1 rvld=10 rdat=0a01",
                     mif_gnt, mif_rvld, hst_rvld, rdat); end
        next_cycle();
        mif_req = 1'b0;
        @(negedge clk);
        total++; if ({mif_rvld, hst_rvld} !== 2'b01 || rdat !== 16'h0B02) begin bad++;
            $display("FAIL b2b_rv1 got rvld=%b%b rdat=%h want rvld=01 rdat=0b02",
                     mif_rvld, hst_rvld, rdat); end
        next_cycle();
        @(negedge clk);
        total++; if ({mif_rvld, hst_rvld} !== 2'b10 || rdat !== 16'h0C03) begin bad++;
            $display("FAIL b2b_rv2 got rvld=%b%b rdat=%h want rvld=10 rdat=0c03",
                     mif_rvld, hst_rvld, rdat); end
        next_cycle();
    endtask

    task automatic test_reset_mid_rmw();
        bd_write(13'h1F8, 16'h0F0F);
        ecc_cor_req = 1'b1; ecc_cor_addr = 13'h1F8; ecc_cor_mask = 16'hFFFF;
        @(negedge clk);
        total++; if (ecc_cor_gnt !== 1'b1) begin bad++;
            $display("FAIL rstmid_gnt got=%b want=1", ecc_cor_gnt); end
        next_cycle();
        ecc_cor_req = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({nfc_ram_cen, nfc_ram_wen, nfc_ram_addr, ecc_cor_done} !==
                     {1'b1, 2'b11, 13'h000, 1'b0}) begin bad++;
            $display("FAIL rstmid_out got cen=%b wen=%b addr=%h done=%b want 1 11 000 0",
                     nfc_ram_cen, nfc_ram_wen, nfc_ram_addr, ecc_cor_done); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({nfc_ram_cen, ecc_cor_done} !== 2'b10) begin bad++;
            $display("FAIL rstmid_nowr got cen=%b done=%b want cen=1 done=0", nfc_ram_cen, ecc_cor_done); end
        next_cycle();
        total++; if (mem[13'h1F8] !== 16'h0F0F) begin bad++;
            $display("FAIL rstmid_mem got=%h want=0f0f", mem[13'h1F8]); end
        mif_req = 1'b1; mif_wr = 1'b0; mif_addr = 13'h1F8;
        @(negedge clk);
        total++; if (mif_gnt !== 1'b1) begin bad++;
            $display("FAIL rstmid_arb got=%b want=1", mif_gnt); end
        next_cycle();
        mif_req = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_random();
        logic [15:0] exp_mem [16];
        rsp_t        rsp_q [$];
        int          busy, wcnt, done_at, eg;
        bit          stim, m_g, e_g, h_g, exp_m, exp_h;
        logic [15:0] exp_d, v;
        int          idx;

        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            exp_mem[i] = v;
            bd_write(13'h100 + 13'(i), v);
        end
        busy = 0; wcnt = 0; done_at = -1;
        m_g = 1'b0; e_g = 1'b0; h_g = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            stim = (c < 1480);
            if (m_g) mif_req = 1'b0;
            if (e_g) ecc_cor_req = 1'b0;
            if (h_g) hst_req = 1'b0;
            if (stim && !mif_req && $urandom_range(0, 1) == 1) begin
                mif_req = 1'b1; mif_wr = 1'($urandom);
                mif_addr = 13'h100 + 13'($urandom_range(0, 15)); mif_wdat = 16'($urandom);
            end
            if (stim && !ecc_cor_req && $urandom_range(0, 5) == 0) begin
                ecc_cor_req = 1'b1;
                ecc_cor_addr = 13'h100 + 13'($urandom_range(0, 15)); ecc_cor_mask = 16'($urandom);
            end
            if (stim && !hst_req && $urandom_range(0, 1) == 1) begin
                hst_req = 1'b1; hst_wr = 1'($urandom); hst_be = 2'($urandom);
                hst_addr = 13'h100 + 13'($urandom_range(0, 15)); hst_wdat = 16'($urandom);
            end
            @(negedge clk);

            eg = 0;
            if (busy == 0) begin
                if (hst_req && wcnt == MAXW) eg = 3;
                else if (mif_req)            eg = 1;
                else if (ecc_cor_req)        eg = 2;
                else if (hst_req)            eg = 3;
            end
            total++;
            if ({mif_gnt, ecc_cor_gnt, hst_gnt} !== {eg == 1, eg == 2, eg == 3}) begin bad++;
                $display("FAIL rand_gnt cyc=%0d got=%b want=%b", c,
                         {mif_gnt, ecc_cor_gnt, hst_gnt}, {eg == 1, eg == 2, eg == 3}); end

            exp_m = 1'b0; exp_h = 1'b0; exp_d = '0;
            if (rsp_q.size() > 0 && rsp_q[0].cyc == c) begin
                exp_m = !rsp_q[0].hst; exp_h = rsp_q[0].hst; exp_d = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end
            total++;
            if ({mif_rvld, hst_rvld} !== {exp_m, exp_h} || ((exp_m || exp_h) && rdat !== exp_d)) begin
                bad++; $display("FAIL rand_rvld cyc=%0d got rvld=%b%b rdat=%h want rvld=%b%b rdat=%h",
                                c, mif_rvld, hst_rvld, rdat, exp_m, exp_h, exp_d); end
            total++;
            if (ecc_cor_done !== (done_at == c)) begin bad++;
                $display("FAIL rand_done cyc=%0d got=%b want=%b", c, ecc_cor_done, done_at == c); end

            case (eg)
                1: begin
                    idx = int'(mif_addr[3:0]);
                    if (mif_wr) exp_mem[idx] = mif_wdat;
                    else rsp_q.push_back('{cyc: c + 2, hst: 1'b0, data: exp_mem[idx]});
                end
                2: begin
                    idx = int'(ecc_cor_addr[3:0]);
                    exp_mem[idx] = exp_mem[idx] ^ ecc_cor_mask;
                    busy = 3;
                    done_at = c + 3;
                end
                3: begin
                    idx = int'(hst_addr[3:0]);
                    if (!hst_wr) rsp_q.push_back('{cyc: c + 2, hst: 1'b1, data: exp_mem[idx]});
                    else begin
                        if (hst_be[1]) exp_mem[idx][15:8] = hst_wdat[15:8];
                        if (hst_be[0]) exp_mem[idx][7:0]  = hst_wdat[7:0];
                    end
                end
                default: if (busy > 0) busy--;
            endcase
            if (eg == 3) wcnt = 0;
            else if (hst_req && wcnt < MAXW) wcnt++;

            m_g = mif_gnt; e_g = ecc_cor_gnt; h_g = hst_gnt;
            next_cycle();
        end
        idle_inputs();

        total++; if (rsp_q.size() != 0) begin bad++;
            $display("FAIL rand_drain got=%0d pending want=0", rsp_q.size()); end
        repeat (2) next_cycle();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (mem[13'h100 + 13'(i)] !== exp_mem[i]) begin bad++;
                $display("FAIL rand_mem addr=%h got=%h want=%h", 13'h100 + 13'(i),
                         mem[13'h100 + 13'(i)], exp_mem[i]); end
        end
    endtask

    initial begin
        idle_inputs();
        bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        test_reset();
        test_mif_read();
        test_starvation();
        test_ecc_rmw();
        test_host_be();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
